// File: rtl/isro_move_seq.sv
// isro_move_seq: command sequencer that turns a (steps, gap) burst command
// into evenly spaced single-cycle move pulses for the ISRO state FSM.
// Optional build macro: ISRO_MOVE_STAT_EN adds a saturating moves_total_o
// counter of all move pulses issued since reset.
module isro_move_seq #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CNT_W-1:0] cmd_steps_i,
  input  logic [GAP_W-1:0] cmd_gap_i,
  input  logic             abort_i,
  output logic             move_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] steps_left_o,
  output logic             done_o,
`ifdef ISRO_MOVE_STAT_EN
  output logic [15:0]      moves_total_o,
`endif
  output logic             aborted_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] steps_dec_s;

  // Floor the decrement at zero so steps_left can never wrap.
  assign steps_dec_s = (steps_q != {CNT_W{1'b0}}) ? (steps_q - CNT_ONE) : {CNT_W{1'b0}};

  // State and datapath registers; reset drops every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      steps_q   <= {CNT_W{1'b0}};
      gap_q     <= GAP_ONE;
      gcnt_q    <= {GAP_W{1'b0}};
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic: accept, pulse, count the gap, finish or abort.
  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        aborted_d = 1'b0;
        // abort is deliberately not looked at here: an accept always wins.
        if (cmd_valid_i) begin
          steps_d = cmd_steps_i;
          gap_d   = (cmd_gap_i == {GAP_W{1'b0}}) ? GAP_ONE : cmd_gap_i;
          state_d = (cmd_steps_i == {CNT_W{1'b0}}) ? S_DONE : S_PULSE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PULSE: begin
        // The pulse of this cycle is already out even if abort is seen now.
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
          steps_d   = {CNT_W{1'b0}};
        end else begin
          steps_d = steps_dec_s;
          gcnt_d  = gap_q;
          state_d = (steps_dec_s == {CNT_W{1'b0}}) ? S_DONE : S_GAP;
        end
      end
      S_GAP: begin
        if (abort_i) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
          steps_d   = {CNT_W{1'b0}};
        end else if (gcnt_q <= GAP_ONE) begin
          state_d = S_PULSE;
        end else begin
          gcnt_d = gcnt_q - GAP_ONE;
        end
      end
      S_DONE: begin
        // aborted_o qualifies done_o only, so clear it on the way out.
        state_d   = S_IDLE;
        aborted_d = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        aborted_d = 1'b0;
      end
    endcase
  end

  assign move_o       = (state_q == S_PULSE);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign cmd_ready_o  = (state_q == S_IDLE);
  assign steps_left_o = steps_q;
  assign aborted_o    = aborted_q;

`ifdef ISRO_MOVE_STAT_EN
  logic [15:0] moves_total_q;

  // Saturating count of issued move pulses (aborted-cycle pulses included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moves_total_q <= 16'd0;
    end else if ((state_q == S_PULSE) && (moves_total_q != 16'hFFFF)) begin
      moves_total_q <= moves_total_q + 16'd1;
    end
  end

  assign moves_total_o = moves_total_q;
`endif

endmodule

// File: tb/tb_isro_move_seq.sv
// Directed self-checking bench for isro_move_seq.
module tb_isro_move_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_steps;
  logic [7:0] cmd_gap;
  logic       abort;
  logic       move_o;
  logic       busy;
  logic [7:0] steps_left;
  logic       done_o;
  logic       aborted;
`ifdef ISRO_MOVE_STAT_EN
  logic [15:0] moves_total;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int mv;
  int dc;
  int guard;

  always #5 clk = ~clk;

  isro_move_seq #(.CNT_W(8), .GAP_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_steps_i  (cmd_steps),
    .cmd_gap_i    (cmd_gap),
    .abort_i      (abort),
    .move_o       (move_o),
    .busy_o       (busy),
    .steps_left_o (steps_left),
    .done_o       (done_o),
`ifdef ISRO_MOVE_STAT_EN
    .moves_total_o(moves_total),
`endif
    .aborted_o    (aborted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_steps = 8'd0; cmd_gap = 8'd0; abort = 1'b0;
    #12;
    chk("rst_ready",   32'(cmd_ready),  32'd1);
    chk("rst_move",    32'(move_o),     32'd0);
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_done",    32'(done_o),     32'd0);
    chk("rst_aborted", 32'(aborted),    32'd0);
    chk("rst_steps",   32'(steps_left), 32'd0);
`ifdef ISRO_MOVE_STAT_EN
    chk("rst_total",   32'(moves_total), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // T2: steps=3 gap=2 -> moves at +1,+4,+7, done at +8
    cmd_steps = 8'd3; cmd_gap = 8'd2; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("t2_move",  32'(move_o), 32'(c == 1 || c == 4 || c == 7));
      chk("t2_done",  32'(done_o), 32'(c == 8));
      chk("t2_abrt",  32'(aborted), 32'd0);
      chk("t2_busy",  32'(busy), 32'(c <= 8));
      chk("t2_ready", 32'(cmd_ready), 32'(c >= 9));
      chk("t2_steps", 32'(steps_left), (c <= 1) ? 32'd3 : (c <= 4) ? 32'd2 : (c <= 7) ? 32'd1 : 32'd0);
      step();
    end

    // T3: steps=0 -> no move, done at +1, ready at +2
    cmd_steps = 8'd0; cmd_gap = 8'd5; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t3_done",  32'(done_o), 32'd1);
    chk("t3_move",  32'(move_o), 32'd0);
    chk("t3_abrt",  32'(aborted), 32'd0);
    chk("t3_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("t3_ready2", 32'(cmd_ready), 32'd1);
    chk("t3_done2",  32'(done_o), 32'd0);
    step();

    // T4: steps=5 gap=0 behaves as gap=1
    cmd_steps = 8'd5; cmd_gap = 8'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    mv = 0;
    for (int c = 1; c <= 11; c++) begin
      if (move_o) mv++;
      chk("t4_move", 32'(move_o), 32'(c <= 9 && (c % 2) == 1));
      chk("t4_done", 32'(done_o), 32'(c == 10));
      step();
    end
    chk("t4_count", 32'(mv), 32'd5);

    // T5: steps=4 gap=3, abort in 2nd gap -> 2 pulses, aborted done
    cmd_steps = 8'd4; cmd_gap = 8'd3; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("t5_move",  32'(move_o), 32'(c == 1 || c == 5));
      chk("t5_done",  32'(done_o), 32'(c == 8));
      chk("t5_abrt",  32'(aborted), 32'(c == 8));
      chk("t5_steps", 32'(steps_left), (c <= 1) ? 32'd4 : (c <= 5) ? 32'd3 : (c <= 7) ? 32'd2 : 32'd0);
      abort = (c == 7);
      step();
    end
    abort = 1'b0;

    // Abort in IDLE ignored (accept wins); abort in PULSE keeps that pulse
    cmd_steps = 8'd2; cmd_gap = 8'd1; cmd_valid = 1'b1; abort = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t7_move",  32'(move_o), 32'd1);
    chk("t7_busy",  32'(busy), 32'd1);
    step();
    abort = 1'b0;
    chk("t7_done",  32'(done_o), 32'd1);
    chk("t7_abrt",  32'(aborted), 32'd1);
    chk("t7_move2", 32'(move_o), 32'd0);
    chk("t7_steps", 32'(steps_left), 32'd0);
    step();
    chk("t7_ready", 32'(cmd_ready), 32'd1);
    chk("t7_abrt2", 32'(aborted), 32'd0);

    // Max step count 255 with gap 0: 255 pulses, done at +510
    cmd_steps = 8'd255; cmd_gap = 8'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("max_steps0", 32'(steps_left), 32'd255);
    mv = 0; dc = 0;
    for (int c = 1; c <= 600; c++) begin
      if (move_o) mv++;
      if (done_o && dc == 0) dc = c;
      step();
    end
    chk("max_count", 32'(mv), 32'd255);
    chk("max_donec", 32'(dc), 32'd510);
`ifdef ISRO_MOVE_STAT_EN
    chk("stat_pre", 32'(moves_total), 32'd266);
`endif

    // T1: asynchronous reset mid-burst, no done afterwards
    cmd_steps = 8'd10; cmd_gap = 8'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t1_move_pre", 32'(move_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_move",  32'(move_o), 32'd0);
    chk("t1_busy",  32'(busy), 32'd0);
    chk("t1_ready", 32'(cmd_ready), 32'd1);
    chk("t1_steps", 32'(steps_left), 32'd0);
    chk("t1_done",  32'(done_o), 32'd0);
`ifdef ISRO_MOVE_STAT_EN
    chk("t1_total", 32'(moves_total), 32'd0);
`endif
    #2 rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t1_nodone", 32'(done_o), 32'd0);
      chk("t1_idle",   32'(busy), 32'd0);
    end

    // T6: two bursts (3, 2) with cmd_valid held throughout
    for (int b = 0; b < 2; b++) begin
      cmd_steps = (b == 0) ? 8'd3 : 8'd2; cmd_gap = 8'd1; cmd_valid = 1'b1;
      step();
      mv = 0; guard = 0;
      while (!done_o && guard < 50) begin
        if (move_o) mv++;
        step();
        guard++;
      end
      chk("t6_done_seen", 32'(done_o), 32'd1);
      chk("t6_count", 32'(mv), (b == 0) ? 32'd3 : 32'd2);
      step();
      chk("t6_no_reaccept", 32'(busy), 32'd0);
      chk("t6_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      step();
    end
`ifdef ISRO_MOVE_STAT_EN
    chk("t6_total", 32'(moves_total), 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
